// File: rtl/gpu_pkg.sv
// Shared types for the frame sequencer: FSM state encoding, voxel word layout
// and palette size.
package gpu_pkg;

  localparam int DEF_COORD_BITS   = 8;
  localparam int DEF_PALETTE_BITS = 8;
  localparam int NUM_PALETTE      = 2**DEF_PALETTE_BITS;

  typedef enum logic [3:0] {
    IDLE, VFETCH, VLOAD, RPULSE, RWAIT,
    PFETCH, PLOAD, SPULSE, SWAIT,
    READOUT, DONE
  } seq_state_t;

  typedef struct packed {
    logic [DEF_COORD_BITS-1:0]   x;
    logic [DEF_COORD_BITS-1:0]   y;
    logic [DEF_COORD_BITS-1:0]   z;
    logic [DEF_PALETTE_BITS-1:0] id;
  } voxel_t;

endpackage

// File: rtl/raster_scan.sv
// Row-major scan of the shader grid for framebuffer readout. The counters
// step while enabled and sit at zero otherwise.
module raster_scan #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  output logic [ROW_BITS-1:0]     row_o,
  output logic [COL_BITS-1:0]     col_o,
  output logic [FB_ADDR_BITS-1:0] fb_addr_o,
  output logic                    done_o
);

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic                last;

  assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (!en_i || last) begin
      row_q <= '0;
      col_q <= '0;
    end else if (col_q == COL_LAST) begin
      col_q <= '0;
      row_q <= row_q + 1'b1;
    end else begin
      col_q <= col_q + 1'b1;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign fb_addr_o = FB_ADDR_BITS'(row_q) * FB_ADDR_BITS'(COLS) + FB_ADDR_BITS'(col_q);
  assign done_o    = en_i & last;

endmodule

// File: rtl/frame_sequencer.sv
// Frame controller: rasterize pass over all voxels, shade pass over every
// palette id, then readout of the shader grid into the framebuffer.
module frame_sequencer
  import gpu_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int VADDR_BITS   = 10,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic [VADDR_BITS:0]                  num_voxels_i,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic [VADDR_BITS-1:0]                voxel_addr_o,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] voxel_rdata_i,
  output logic [PALETTE_BITS-1:0]              palette_addr_o,
  input  logic [PIXEL_BITS-1:0]                palette_rdata_i,
  output logic [COORD_BITS-1:0]                voxel_x_o,
  output logic [COORD_BITS-1:0]                voxel_y_o,
  output logic [COORD_BITS-1:0]                voxel_z_o,
  output logic [PALETTE_BITS-1:0]              voxel_id_o,
  output logic [PIXEL_BITS-1:0]                palette_entry_o,
  output logic                                 do_rasterize_o,
  output logic                                 do_shade_o,
  input  logic                                 rasterizing_done_i,
  input  logic                                 shading_done_i,
  output logic [ROW_BITS-1:0]                  row_o,
  output logic [COL_BITS-1:0]                  col_o,
  input  logic [PIXEL_BITS-1:0]                pixel_i,
  output logic                                 fb_we_o,
  output logic [FB_ADDR_BITS-1:0]              fb_addr_o,
  output logic [PIXEL_BITS-1:0]                fb_wdata_o
);

  localparam logic [PALETTE_BITS:0] PI_END = {1'b1, {PALETTE_BITS{1'b0}}};

  seq_state_t              state_q;
  logic [VADDR_BITS:0]     num_q;
  logic [VADDR_BITS:0]     vi_q;
  logic [PALETTE_BITS:0]   pi_q;
  logic [VADDR_BITS-1:0]   voxel_addr_q;
  logic [PALETTE_BITS-1:0] palette_addr_q;
  voxel_t                  voxel_q;
  logic [PIXEL_BITS-1:0]   palette_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic                    do_rasterize_q;
  logic                    do_shade_q;

  logic [VADDR_BITS:0]     vi_inc;
  logic [PALETTE_BITS:0]   pi_inc;
  logic                    scan_en;
  logic                    scan_done;

  assign vi_inc  = vi_q + 1'b1;
  assign pi_inc  = pi_q + 1'b1;
  assign scan_en = (state_q == READOUT);

  // Pulses are registered on entry to the PULSE state, so each is one cycle wide.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      num_q          <= '0;
      vi_q           <= '0;
      pi_q           <= '0;
      voxel_addr_q   <= '0;
      palette_addr_q <= '0;
      voxel_q        <= '0;
      palette_q      <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      do_rasterize_q <= 1'b0;
      do_shade_q     <= 1'b0;
    end else begin
      frame_done_q   <= 1'b0;
      do_rasterize_q <= 1'b0;
      do_shade_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            num_q  <= num_voxels_i;
            vi_q   <= '0;
            pi_q   <= '0;
            busy_q <= 1'b1;
            if (num_voxels_i == '0) begin
              palette_addr_q <= '0;
              state_q        <= PFETCH;
            end else begin
              voxel_addr_q <= '0;
              state_q      <= VFETCH;
            end
          end
        end
        VFETCH: state_q <= VLOAD;
        VLOAD: begin
          voxel_q        <= voxel_t'(voxel_rdata_i);
          do_rasterize_q <= 1'b1;
          state_q        <= RPULSE;
        end
        RPULSE: state_q <= RWAIT;
        RWAIT: begin
          if (rasterizing_done_i) begin
            vi_q <= vi_inc;
            if (vi_inc == num_q) begin
              pi_q           <= '0;
              palette_addr_q <= '0;
              state_q        <= PFETCH;
            end else begin
              voxel_addr_q <= vi_inc[VADDR_BITS-1:0];
              state_q      <= VFETCH;
            end
          end
        end
        PFETCH: state_q <= PLOAD;
        PLOAD: begin
          palette_q  <= palette_rdata_i;
          voxel_q.id <= pi_q[PALETTE_BITS-1:0];
          do_shade_q <= 1'b1;
          state_q    <= SPULSE;
        end
        SPULSE: state_q <= SWAIT;
        SWAIT: begin
          if (shading_done_i) begin
            if (pi_inc == PI_END) begin
              pi_q    <= '0;
              state_q <= READOUT;
            end else begin
              pi_q           <= pi_inc;
              palette_addr_q <= pi_inc[PALETTE_BITS-1:0];
              state_q        <= PFETCH;
            end
          end
        end
        READOUT: begin
          if (scan_done) begin
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  raster_scan #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .ROW_BITS     (ROW_BITS),
    .COL_BITS     (COL_BITS),
    .FB_ADDR_BITS (FB_ADDR_BITS)
  ) u_scan (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .en_i      (scan_en),
    .row_o     (row_o),
    .col_o     (col_o),
    .fb_addr_o (fb_addr_o),
    .done_o    (scan_done)
  );

  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
  assign voxel_addr_o    = voxel_addr_q;
  assign palette_addr_o  = palette_addr_q;
  assign voxel_x_o       = voxel_q.x;
  assign voxel_y_o       = voxel_q.y;
  assign voxel_z_o       = voxel_q.z;
  assign voxel_id_o      = voxel_q.id;
  assign palette_entry_o = palette_q;
  assign do_rasterize_o  = do_rasterize_q;
  assign do_shade_o      = do_shade_q;
  assign fb_we_o         = scan_en;
  assign fb_wdata_o      = scan_en ? pixel_i : '0;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized frame-level bench for frame_sequencer with RAM, shader and
// pixel-bus models; expectations come from the RAM contents and frame timing rules.
module tb_frame_sequencer;
  import gpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] num_voxels = '0;
  logic        busy, frame_done;
  logic [9:0]  voxel_addr;
  logic [31:0] voxel_rdata;
  logic [7:0]  palette_addr, palette_rdata;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
  logic        do_rasterize, do_shade;
  logic        rasterizing_done, shading_done;
  logic [7:0]  row, col, pixel;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_wdata;

  always #5 clock = ~clock;

  frame_sequencer dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .num_voxels_i(num_voxels),
    .busy_o(busy), .frame_done_o(frame_done),
    .voxel_addr_o(voxel_addr), .voxel_rdata_i(voxel_rdata),
    .palette_addr_o(palette_addr), .palette_rdata_i(palette_rdata),
    .voxel_x_o(voxel_x), .voxel_y_o(voxel_y), .voxel_z_o(voxel_z), .voxel_id_o(voxel_id),
    .palette_entry_o(palette_entry),
    .do_rasterize_o(do_rasterize), .do_shade_o(do_shade),
    .rasterizing_done_i(rasterizing_done), .shading_done_i(shading_done),
    .row_o(row), .col_o(col), .pixel_i(pixel),
    .fb_we_o(fb_we), .fb_addr_o(fb_addr), .fb_wdata_o(fb_wdata)
  );

  // Memories with one-cycle read latency.
  logic [31:0] vram [0:15];
  logic [7:0]  pal  [0:255];
  always @(posedge clock) begin
    voxel_rdata   <= vram[voxel_addr[3:0]];
    palette_rdata <= pal[palette_addr];
  end

  // Pixel bus: each shader reports row*16+col.
  assign pixel = 8'((int'(row) * 16) + int'(col));

  // Shader model: done pulse d_cyc cycles after each command pulse.
  int   d_cyc = 5;
  int   rcnt, scnt;
  logic rdone_m, sdone_m;
  logic rdone_inj = 1'b0, sdone_inj = 1'b0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt <= 0; scnt <= 0; rdone_m <= 1'b0; sdone_m <= 1'b0;
    end else begin
      rdone_m <= (rcnt == 1);
      sdone_m <= (scnt == 1);
      if (do_rasterize) rcnt <= d_cyc - 1; else if (rcnt != 0) rcnt <= rcnt - 1;
      if (do_shade)     scnt <= d_cyc - 1; else if (scnt != 0) scnt <= scnt - 1;
    end
  end
  assign rasterizing_done = rdone_m | rdone_inj;
  assign shading_done     = sdone_m | sdone_inj;

  logic [102:0] all_out;
  assign all_out = {busy, frame_done, voxel_addr, palette_addr, voxel_x, voxel_y, voxel_z,
                    voxel_id, palette_entry, do_rasterize, do_shade, row, col, fb_we,
                    fb_addr, fb_wdata};

  int checks = 0;
  int failures = 0;

  int          raddr_q[$];
  logic [31:0] rdata_q[$];
  int          sid_q[$];
  int          sent_q[$];
  int          faddr_q[$];
  int          fdata_q[$];
  int          done_cyc, first_r_cyc, first_s_cyc;
  logic        busy_at_done;
  int          stab_err, b2b_err, extra_done, busy_after, inj_fired;

  task automatic fill_rams();
    for (int i = 0; i < 16; i++) vram[i] = $urandom;
    for (int j = 0; j < 256; j++) pal[j] = 8'($urandom_range(0, 255));
    pal[7] = 8'hA5;
  endtask

  task automatic capture(input int bound);
    int cyc;
    bit prev_r, prev_s, in_r, in_s;
    logic [31:0] rsnap;
    logic [15:0] ssnap;
    cyc = 1; prev_r = 0; prev_s = 0; in_r = 0; in_s = 0; rsnap = '0; ssnap = '0;
    forever begin
      if (in_r) begin
        if ({voxel_x, voxel_y, voxel_z, voxel_id} !== rsnap) stab_err++;
        if (rasterizing_done) in_r = 0;
      end
      if (in_s) begin
        if ({voxel_id, palette_entry} !== ssnap) stab_err++;
        if (shading_done) in_s = 0;
      end
      if (do_rasterize) begin
        if (prev_r) b2b_err++;
        if (first_r_cyc < 0) first_r_cyc = cyc;
        raddr_q.push_back(int'(voxel_addr));
        rsnap = {voxel_x, voxel_y, voxel_z, voxel_id};
        rdata_q.push_back(rsnap);
        in_r = 1;
      end
      if (do_shade) begin
        if (prev_s) b2b_err++;
        if (first_s_cyc < 0) first_s_cyc = cyc;
        sid_q.push_back(int'(voxel_id));
        sent_q.push_back(int'(palette_entry));
        ssnap = {voxel_id, palette_entry};
        in_s = 1;
      end
      if (fb_we) begin
        faddr_q.push_back(int'(fb_addr));
        fdata_q.push_back(int'(fb_wdata));
      end
      prev_r = do_rasterize;
      prev_s = do_shade;
      if (frame_done) begin
        done_cyc = cyc;
        busy_at_done = busy;
        break;
      end
      if (cyc >= bound) break;
      @(negedge clock);
      cyc++;
    end
  endtask

  // start during RWAIT plus spurious shading_done there; spurious rasterizing_done in SWAIT.
  task automatic injector(input int bound);
    int i;
    i = 0;
    while (!do_rasterize && i < bound) begin @(negedge clock); i++; end
    if (do_rasterize) begin
      @(negedge clock); start = 1'b1; sdone_inj = 1'b1;
      @(negedge clock); start = 1'b0; sdone_inj = 1'b0;
      inj_fired++;
    end
    i = 0;
    while (!do_shade && i < bound) begin @(negedge clock); i++; end
    if (do_shade) begin
      @(negedge clock); rdone_inj = 1'b1;
      @(negedge clock); rdone_inj = 1'b0;
      inj_fired++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_outputs got %h exp 0", all_out); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL idle_outputs got %h exp 0", all_out); end
  endtask

  task automatic test_frame(input int n, input int d, input bit inject, input string tag);
    int exp_done, exp_first_s, exp_px;
    fill_rams();
    d_cyc = d;
    raddr_q.delete(); rdata_q.delete(); sid_q.delete(); sent_q.delete();
    faddr_q.delete(); fdata_q.delete();
    done_cyc = -1; first_r_cyc = -1; first_s_cyc = -1; busy_at_done = 1'bx;
    stab_err = 0; b2b_err = 0; extra_done = 0; busy_after = 0; inj_fired = 0;
    exp_done    = 1 + n*(3+d) + NUM_PALETTE*(3+d) + 16 + 1 - 1;
    exp_first_s = 3 + n*(3+d);

    @(negedge clock); num_voxels = 11'(n); start = 1'b1;
    @(negedge clock); start = 1'b0;
    fork
      capture(4000);
      if (inject) injector(3000);
    join
    repeat (8) begin
      @(negedge clock);
      if (frame_done) extra_done++;
      if (busy) busy_after++;
    end

    checks++;
    if (done_cyc != exp_done) begin failures++; $display("FAIL %s frame_done_cycle got %0d exp %0d", tag, done_cyc, exp_done); end
    checks++;
    if (busy_at_done !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got %b exp 0", tag, busy_at_done); end
    checks++;
    if (raddr_q.size() != n) begin failures++; $display("FAIL %s raster_pulses got %0d exp %0d", tag, raddr_q.size(), n); end
    for (int k = 0; k < raddr_q.size() && k < n; k++) begin
      checks++;
      if (raddr_q[k] != k) begin failures++; $display("FAIL %s voxel_addr[%0d] got %0d exp %0d", tag, k, raddr_q[k], k); end
      checks++;
      if (rdata_q[k] !== vram[k]) begin failures++; $display("FAIL %s voxel_bcast[%0d] got %h exp %h", tag, k, rdata_q[k], vram[k]); end
    end
    if (n > 0) begin
      checks++;
      if (first_r_cyc != 3) begin failures++; $display("FAIL %s first_raster_cycle got %0d exp 3", tag, first_r_cyc); end
    end
    checks++;
    if (first_s_cyc != exp_first_s) begin failures++; $display("FAIL %s first_shade_cycle got %0d exp %0d", tag, first_s_cyc, exp_first_s); end
    checks++;
    if (sid_q.size() != NUM_PALETTE) begin failures++; $display("FAIL %s shade_pulses got %0d exp %0d", tag, sid_q.size(), NUM_PALETTE); end
    for (int j = 0; j < sid_q.size() && j < NUM_PALETTE; j++) begin
      checks++;
      if (sid_q[j] != j) begin failures++; $display("FAIL %s shade_id[%0d] got %0d exp %0d", tag, j, sid_q[j], j); end
      checks++;
      if (sent_q[j] != int'(pal[j])) begin failures++; $display("FAIL %s palette_entry[%0d] got %h exp %h", tag, j, sent_q[j], pal[j]); end
    end
    if (sent_q.size() > 7) begin
      checks++;
      if (sid_q[7] != 7 || sent_q[7] != 'hA5) begin failures++; $display("FAIL %s shade7 got id %0d entry %h exp id 7 entry a5", tag, sid_q[7], sent_q[7]); end
    end
    checks++;
    if (faddr_q.size() != 16) begin failures++; $display("FAIL %s fb_writes got %0d exp 16", tag, faddr_q.size()); end
    for (int k = 0; k < faddr_q.size() && k < 16; k++) begin
      exp_px = (k / 4) * 16 + (k % 4);
      checks++;
      if (faddr_q[k] != k) begin failures++; $display("FAIL %s fb_addr[%0d] got %0d exp %0d", tag, k, faddr_q[k], k); end
      checks++;
      if (fdata_q[k] != exp_px) begin failures++; $display("FAIL %s fb_wdata[%0d] got %h exp %h", tag, k, fdata_q[k], exp_px); end
    end
    if (fdata_q.size() > 9) begin
      checks++;
      if (fdata_q[9] != 'h21) begin failures++; $display("FAIL %s fb_addr9_data got %h exp 21", tag, fdata_q[9]); end
    end
    checks++;
    if (stab_err != 0) begin failures++; $display("FAIL %s broadcast_stability got %0d changes exp 0", tag, stab_err); end
    checks++;
    if (b2b_err != 0) begin failures++; $display("FAIL %s back_to_back_pulses got %0d exp 0", tag, b2b_err); end
    checks++;
    if (extra_done != 0 || busy_after != 0) begin failures++; $display("FAIL %s after_frame got done %0d busy %0d exp 0 0", tag, extra_done, busy_after); end
    if (inject) begin
      checks++;
      if (inj_fired != 2) begin failures++; $display("FAIL %s injections got %0d exp 2", tag, inj_fired); end
    end
  endtask

  task automatic test_reset_mid();
    int i, ns, fd_cnt, busy_cnt;
    fill_rams();
    d_cyc = 4;
    @(negedge clock); num_voxels = 11'd2; start = 1'b1;
    @(negedge clock); start = 1'b0;
    ns = 0; i = 0;
    while (ns < 10 && i < 2000) begin
      if (do_shade) ns++;
      if (ns < 10) begin @(negedge clock); i++; end
    end
    checks++;
    if (ns != 10) begin failures++; $display("FAIL reset_mid_reach_swait got %0d pulses exp 10", ns); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin failures++; $display("FAIL reset_mid_outputs got %h exp 0", all_out); end
    @(negedge clock);
    reset = 1'b0;
    fd_cnt = 0; busy_cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (frame_done) fd_cnt++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (fd_cnt != 0 || busy_cnt != 0) begin failures++; $display("FAIL reset_mid_aftermath got done %0d busy %0d exp 0 0", fd_cnt, busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame(3, 5, 1'b0, "basic");
    test_frame(0, 4, 1'b0, "zero_voxels");
    test_frame(4, 3, 1'b1, "busy_ignore");
    for (int r = 0; r < 2; r++)
      test_frame(int'($urandom_range(1, 6)), int'($urandom_range(2, 6)), 1'b0, "random");
    test_reset_mid();
    test_frame(2, 3, 1'b0, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
